// File: rtl/vga_pkg.sv
// vga_pkg: XGA 1024x768@60 timing constants shared by the timing generator and draw stages
package vga_pkg;
  localparam int CNT_W          = 11;
  localparam int XGA_H_ACTIVE   = 1024;
  localparam int XGA_H_FP       = 24;
  localparam int XGA_H_SYNC     = 136;
  localparam int XGA_H_BP       = 160;
  localparam int XGA_V_ACTIVE   = 768;
  localparam int XGA_V_FP       = 3;
  localparam int XGA_V_SYNC     = 6;
  localparam int XGA_V_BP       = 29;
  localparam bit XGA_SYNC_POL   = 1'b0;
  localparam int H_TOTAL        = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int V_TOTAL        = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;
  localparam int H_ACTIVE_LAST  = XGA_H_ACTIVE - 1;
  localparam int V_ACTIVE_LAST  = XGA_V_ACTIVE - 1;
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle passed from the timing generator to draw stages
interface vga_timing_if;
  import vga_pkg::*;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hblnk;
  logic             vblnk;
  logic             hsync;
  logic             vsync;
  logic             frame_start;
  modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start);
  modport slave  (input  hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter with blank/sync decoded from its next state
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = XGA_H_ACTIVE,
  parameter int FP     = XGA_H_FP,
  parameter int SYNC   = XGA_H_SYNC,
  parameter int BP     = XGA_H_BP,
  parameter bit POL    = XGA_SYNC_POL
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] S_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] S_END = CNT_W'(ACTIVE + FP + SYNC - 1);
  logic [CNT_W-1:0] count_q, count_d;
  logic             blnk_q, sync_q;
  // next count: wrap at the last position (>= keeps it safe from any out-of-range value)
  always_comb begin
    wrap    = advance && count_q >= LAST;
    count_d = wrap ? '0 : count_q + CNT_W'(advance);
  end
  // register count with blank/sync decoded from the next count so all three stay aligned
  always_ff @(posedge pclk) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blnk_q  <= count_d >= ACT;
      sync_q  <= (count_d >= S_BEG && count_d <= S_END) ? POL : ~POL;
    end
  end
  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: head of the display pipeline, generating registered raster timing
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit SYNC_POL = XGA_SYNC_POL
) (
  input  logic         pclk,
  input  logic         rst,
  vga_timing_if.master vga
);
  logic [CNT_W-1:0] hcount, vcount;
  logic             hblnk, vblnk, hsync, vsync, h_wrap, v_wrap;
  logic             frame_start_q;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(SYNC_POL)) u_h (
    .pclk(pclk), .rst(rst), .advance(1'b1),
    .count(hcount), .blnk(hblnk), .sync(hsync), .wrap(h_wrap)
  );
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(SYNC_POL)) u_v (
    .pclk(pclk), .rst(rst), .advance(h_wrap),
    .count(vcount), .blnk(vblnk), .sync(vsync), .wrap(v_wrap)
  );
  // frame start marks the (0,0) state: reset or the cycle after the joint line/frame wrap
  always_ff @(posedge pclk) begin
    frame_start_q <= rst | v_wrap;
  end
  assign vga.hcount      = hcount;
  assign vga.vcount      = vcount;
  assign vga.hblnk       = hblnk;
  assign vga.vblnk       = vblnk;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of XGA timing plus a shrunken active-high-sync instance for full frames
module tb_vga_timing;
  typedef struct {
    int          t;
    logic [10:0] h;
    logic [10:0] v;
    logic [4:0]  f;
  } vec_t;
  logic pclk = 1'b0;
  logic rst_a, rst_b;
  int   tests = 0;
  int   fails = 0;
  int   t;
  vec_t va [11];
  vec_t vb [14];
  vga_timing_if ifa ();
  vga_timing_if ifb ();
  vga_timing u_a (.pclk(pclk), .rst(rst_a), .vga(ifa));
  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1)
  ) u_b (.pclk(pclk), .rst(rst_b), .vga(ifb));
  always #5 pclk = ~pclk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  function automatic logic [26:0] snap(input bit b);
    return b ? {ifb.hcount, ifb.vcount, ifb.hblnk, ifb.vblnk, ifb.hsync, ifb.vsync, ifb.frame_start}
             : {ifa.hcount, ifa.vcount, ifa.hblnk, ifa.vblnk, ifa.hsync, ifa.vsync, ifa.frame_start};
  endfunction
  task automatic check(input string nm, input bit b, input logic [10:0] h, input logic [10:0] v, input logic [4:0] f);
    logic [26:0] got;
    got = snap(b);
    tests++;
    if (got !== {h, v, f}) begin
      fails++;
      $display("FAIL %s: got h=%0d v=%0d hb/vb/hs/vs/fs=%b, want h=%0d v=%0d hb/vb/hs/vs/fs=%b",
               nm, got[26:16], got[15:5], got[4:0], h, v, f);
    end
  endtask
  task automatic check_int(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask
  initial begin
    int n, hs_lo, hb_hi, vs_hi, hs_hi, fs_cnt;
    va = '{
      '{1,     11'd1,    11'd0,  5'b00110},
      '{1023,  11'd1023, 11'd0,  5'b00110},
      '{1024,  11'd1024, 11'd0,  5'b10110},
      '{1047,  11'd1047, 11'd0,  5'b10110},
      '{1048,  11'd1048, 11'd0,  5'b10010},
      '{1183,  11'd1183, 11'd0,  5'b10010},
      '{1184,  11'd1184, 11'd0,  5'b10110},
      '{1343,  11'd1343, 11'd0,  5'b10110},
      '{1344,  11'd0,    11'd1,  5'b00110},
      '{14783, 11'd1343, 11'd10, 5'b10110},
      '{14784, 11'd0,    11'd11, 5'b00110}
    };
    vb = '{
      '{1,   11'd1,  11'd0,  5'b00000},
      '{18,  11'd18, 11'd0,  5'b10100},
      '{20,  11'd20, 11'd0,  5'b10100},
      '{21,  11'd21, 11'd0,  5'b10000},
      '{24,  11'd24, 11'd0,  5'b10000},
      '{25,  11'd0,  11'd1,  5'b00000},
      '{200, 11'd0,  11'd8,  5'b01000},
      '{224, 11'd24, 11'd8,  5'b11000},
      '{225, 11'd0,  11'd9,  5'b01010},
      '{274, 11'd24, 11'd10, 5'b11010},
      '{275, 11'd0,  11'd11, 5'b01000},
      '{349, 11'd24, 11'd13, 5'b11000},
      '{350, 11'd0,  11'd0,  5'b00001},
      '{351, 11'd1,  11'd0,  5'b00000}
    };
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("reset_a", 1'b0, 11'd0, 11'd0, 5'b00111);
    check("reset_b", 1'b1, 11'd0, 11'd0, 5'b00001);
    rst_a = 1'b0;
    t = 0;
    foreach (va[i]) begin
      while (t < va[i].t) begin
        tick();
        t++;
      end
      check($sformatf("xga_t%0d", va[i].t), 1'b0, va[i].h, va[i].v, va[i].f);
    end
    hs_lo = 0;
    hb_hi = 0;
    for (int i = 0; i < 1344; i++) begin
      tick();
      hs_lo += int'(!ifa.hsync);
      hb_hi += int'(ifa.hblnk);
    end
    check_int("xga_hsync_width", hs_lo, 136);
    check_int("xga_hblnk_width", hb_hi, 320);
    for (int i = 0; i < 500; i++) tick();
    check("xga_pre_reset", 1'b0, 11'd500, 11'd12, 5'b00110);
    rst_a = 1'b1;
    tick();
    check("xga_mid_reset", 1'b0, 11'd0, 11'd0, 5'b00111);
    rst_a = 1'b0;
    tick();
    check("xga_restart", 1'b0, 11'd1, 11'd0, 5'b00110);
    for (int i = 0; i < 1343; i++) tick();
    check("xga_restart_line", 1'b0, 11'd0, 11'd1, 5'b00110);
    rst_b = 1'b0;
    t = 0;
    foreach (vb[i]) begin
      while (t < vb[i].t) begin
        tick();
        t++;
      end
      check($sformatf("small_t%0d", vb[i].t), 1'b1, vb[i].h, vb[i].v, vb[i].f);
    end
    n = 0;
    while (!ifb.frame_start && n < 1000) begin
      tick();
      n++;
    end
    check_int("small_frame_period", n, 349);
    vs_hi = 0;
    hs_hi = 0;
    fs_cnt = 0;
    for (int i = 0; i < 350; i++) begin
      tick();
      vs_hi += int'(ifb.vsync);
      hs_hi += int'(ifb.hsync);
      fs_cnt += int'(ifb.frame_start);
    end
    check_int("small_vsync_width", vs_hi, 50);
    check_int("small_hsync_per_frame", hs_hi, 42);
    check_int("small_fs_per_frame", fs_cnt, 1);
    for (int i = 0; i < 132; i++) tick();
    check("small_pre_reset", 1'b1, 11'd7, 11'd5, 5'b00000);
    rst_b = 1'b1;
    tick();
    check("small_mid_reset", 1'b1, 11'd0, 11'd0, 5'b00001);
    rst_b = 1'b0;
    tick();
    check("small_restart", 1'b1, 11'd1, 11'd0, 5'b00000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the XGA 1024x768 @ 60 Hz raster timing (65 MHz pixel clock) that drives the display pipeline. It produces pixel/line counters, blanking and sync strobes, and a frame-start pulse. Downstream draw stages (background, menu, ball, paddles) take these unchanged as their `*_in` timing inputs and delay them by one register each. This block is the head of that chain; every other stage aligns to its outputs.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, horizontal sync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `SYNC_POL`, 0, sync active level (0 = active-low, the XGA default; 1 = active-high)

Ports:
- `pclk` input 1: pixel clock, 65 MHz; single clock domain
- `rst` input 1: reset, synchronous, active-high
- `hcount` output 11: current pixel index within the line
- `vcount` output 11: current line index within the frame
- `hblnk` output 1: high when `hcount >= H_ACTIVE`
- `vblnk` output 1: high when `vcount >= V_ACTIVE`
- `hsync` output 1: at `SYNC_POL` level inside the horizontal sync window, inverse otherwise
- `vsync` output 1: at `SYNC_POL` level inside the vertical sync window, inverse otherwise
- `frame_start` output 1: high for exactly one cycle, while `hcount==0 && vcount==0`

## Operation
- Derived constants: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (1344) and `V_TOTAL` (806).
- Horizontal counter:
  - Increments every cycle.
  - At `H_TOTAL-1` it wraps to 0 and the vertical counter advances.
- Vertical counter:
  - Advances only on horizontal wrap.
  - At `V_TOTAL-1` it wraps to 0. The two wraps happen in the same cycle at (1343, 805).
- Horizontal sync window: `H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1`, i.e. [1048, 1183].
- Vertical sync window: `V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1`, i.e. [771, 776]. `vsync` changes only together with a `vcount` change, at `hcount==0`.
- All outputs are registers. Blank, sync and `frame_start` are decoded from the next-state counter values, so in every cycle they are consistent with the `hcount`/`vcount` values presented in that same cycle. There is no combinational path to any output.
- Counter arithmetic is unsigned 11 bits. Both totals are below 2048, so there is no overflow. The compare logic must not depend on the counters ever reaching values at or above the totals.

## Timing
- Reset values while `rst` is high:
  - `hcount=0`, `vcount=0`
  - `hblnk=0`, `vblnk=0`
  - `hsync=vsync=~SYNC_POL`
  - `frame_start=1`
  - This is the (0,0) state.
- First cycle after `rst` deasserts: outputs show (1,0), `frame_start=0`.
- Reset asserted mid-frame:
  - Next edge forces the (0,0) state, whatever the counter values were.
  - No partial-line or partial-frame completion.
- Period: line = 1344 cycles; frame = 1344 × 806 = 1,083,264 cycles.
- `frame_start` recurs exactly once per frame period.
- Latency: none relative to the counters. Downstream stages add their own single-register delay.

## Structure
- Package `vga_pkg` holds:
  - XGA timing constants (the eight parameter defaults)
  - derived `H_TOTAL`/`V_TOTAL`
  - the counter width constant (11)
  
  Draw stages import the same package for active-area limits (767, 1023).
- One sub-module: `vga_axis_counter`.
  - Parameterised by active/fp/sync/bp.
  - Ports: `pclk`, `rst`, `advance`, `count`, `blnk`, `sync`, `wrap`.
  - Instantiated twice: horizontal instance with `advance=1`; vertical instance with `advance` = the horizontal `wrap`.
- The top level adds only the `frame_start` decode and the sync polarity.

## Test plan
- Reset: hold `rst` for 3 cycles, then release.
  - Required: (0,0), blanks 0, syncs 1, `frame_start=1` during reset.
  - Required: (1,0), `frame_start=0` on the first cycle after release.
- Line wrap: run to `hcount=1343, vcount=10`, then one cycle.
  - Required: (0,11) with `hblnk` going 1→0.
- `hblnk` onset: `hblnk` rises exactly at `hcount=1024`.
- `hsync` edges: `hsync` falls at `hcount=1048` and rises at `hcount=1184`; pulse width 136.
- Vertical edges: `vblnk` rises at (0,768); `vsync` is low for lines 771–776; pulse width 6 × 1344 = 8064 cycles.
- Frame wrap: at (1343,805), then one cycle.
  - Required: (0,0) with `frame_start=1`.
  - Required: the next `frame_start` arrives exactly 1,083,264 cycles later.
- Reset mid-operation: assert `rst` at (500,400).
  - Required: (0,0) with reset values on the next edge.
  - Required: counting restarts normally after release.
  - Also repeat the bench with `SYNC_POL=1` and check that both syncs are inverted.
